codec_reg_arbiter: RTL and testbench
====================================

// Module: codec_reg_arbiter
// PURPOSE
//  Shares the single CODEC register port of controller_unit_top (rd_en/wr_en/addr/data/busy)
//  among NUM_REQ requesters, e.g. the AXI register host and the sample-rate config sequencer.
//  Round-robin grant, one transaction in flight, busy-handshake sequencing, timeout-protected.
//  Sits in the board_clk domain between requesters and controller_unit_top.
// PARAMETERS
//  NUM_REQ     2     number of requesters (>=2)
//  START_TO    64    cycles to wait for codec_busy rise after issue before error
//  DONE_TO     65535 cycles to wait for transaction completion before error
// PORTS
//  clk              in   1          board clock
//  reset_n          in   1          async active-low reset
//  req_valid        in   NUM_REQ    request pending, held until req_ready
//  req_wr           in   NUM_REQ    1=write, 0=read
//  req_addr         in   8*NUM_REQ  CODEC register address, slice i = [8i+7:8i]
//  req_wdata        in   8*NUM_REQ  write data, slice per requester
//  req_ready        out  NUM_REQ    one-cycle accept pulse, one-hot
//  rsp_valid        out  NUM_REQ    one-cycle completion pulse, one-hot
//  rsp_rdata        out  8          read data, valid with rsp_valid
//  rsp_err          out  1          timeout flag, valid with rsp_valid
//  codec_rd_en      out  1          one-cycle read strobe to controller
//  codec_wr_en      out  1          one-cycle write strobe to controller
//  codec_reg_addr   out  8          address, held from ISSUE until IDLE
//  codec_data_in    out  8          write data, held from ISSUE until IDLE
//  codec_busy       in   1          controller_busy
//  codec_data_out   in   8          controller read data
//  codec_data_valid in   1          controller read data valid
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs 0, FSM=IDLE, rr pointer=0, counters=0.
//  - FSM: IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> RESP -> IDLE.
//  - IDLE: if any req_valid and codec_busy=0, pick first valid at or after pointer (wrapping
//    NUM_REQ-1 -> 0); latch index, wr, addr, wdata; go ISSUE. With codec_busy=1, stay in IDLE.
//  - ISSUE (1 cycle): req_ready[idx]=1; codec_wr_en=wr or codec_rd_en=!wr; pointer <= idx+1 mod NUM_REQ.
//  - Accept latency: req_valid seen in IDLE at cycle t -> req_ready and strobe at t+1.
//  - WAIT_START: busy=1 -> WAIT_DONE, counter cleared. Counter reaches START_TO -> RESP, err=1.
//  - WAIT_DONE: capture codec_data_out when codec_data_valid=1 (sticky flag). Exit to RESP when
//    busy=0 and (write, or read with flag set). Counter reaches DONE_TO -> RESP, err=1.
//  - RESP (1 cycle): rsp_valid[idx]=1; rsp_rdata = captured data (read, no err) else 0; rsp_err.
//    Then -> IDLE; new arbitration no earlier than the cycle after RESP.
//  - codec_data_valid outside WAIT_DONE: ignored. busy falling in WAIT_START: ignored (no rise seen).
//  - req_valid dropped before req_ready: protocol violation. Request is latched at arbitration;
//    later changes to req_* fields have no effect.
//  - Counters saturate at their timeout value; sized $clog2(DONE_TO+1).
//  - reset_n low mid-transaction: FSM aborts, no rsp_valid, strobes low immediately.
// TESTING
//  1. Req0 write addr 0x04 data 0x5A, busy high 2..10 cyc later -> ready0 @t+1, wr_en 1 cyc,
//     addr=0x04/data=0x5A held, rsp_valid0 1 cyc after busy falls, err=0.
//  2. Req1 read 0x0A, valid with data 0xC3 mid-busy -> rsp_valid1, rsp_rdata=0xC3, err=0.
//  3. Req0 and req1 valid same cycle, back-to-back x4 -> grants 0,1,0,1; never both ready.
//  4. Busy never rises -> rsp_valid after START_TO+2 cycles with err=1, rdata=0x00.
//  5. Read: busy falls without data_valid, valid arrives 5 cycles later -> rsp held until valid,
//     then rdata correct, err=0.
//  6. reset_n low in WAIT_DONE -> all outputs 0 at once, no rsp; next request granted normally.

Source files
------------

// File: rtl/codec_reg_arbiter.sv
// codec_reg_arbiter
//   Shares the single CODEC register port of controller_unit_top among NUM_REQ
//   requesters. Round-robin grant, one transaction in flight, sequenced on the
//   controller busy handshake, with start/done timeouts reported as rsp_err.
//
// Ports
//   clk, reset_n                      board clock, async active-low reset
//   req_valid/req_wr[NUM_REQ]         request pending / 1=write
//   req_addr/req_wdata[8*NUM_REQ]     per-requester address and write data
//   req_ready[NUM_REQ]                one-hot accept pulse
//   rsp_valid[NUM_REQ]                one-hot completion pulse
//   rsp_rdata[8], rsp_err             read data / timeout flag, valid with rsp_valid
//   codec_rd_en, codec_wr_en          one-cycle strobes to the controller
//   codec_reg_addr, codec_data_in     held for the whole transaction
//   codec_busy, codec_data_out, codec_data_valid   controller status / read data
module codec_reg_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int START_TO = 64,
  parameter int DONE_TO  = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_wr,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 codec_rd_en,
  output logic                 codec_wr_en,
  output logic [7:0]           codec_reg_addr,
  output logic [7:0]           codec_data_in,
  input  logic                 codec_busy,
  input  logic [7:0]           codec_data_out,
  input  logic                 codec_data_valid
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW1 = IW + 1;
  localparam int CW  = $clog2(DONE_TO + 1);
  localparam logic [CW-1:0]      START_LIM = CW'(START_TO);
  localparam logic [CW-1:0]      DONE_LIM  = CW'(DONE_TO);
  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_RESP
  } state_t;

  state_t                    state;
  logic [IW-1:0]             ptr;
  logic [IW-1:0]             idx;
  logic                      is_wr;
  logic [CW-1:0]             cnt;
  logic                      have_data;
  logic [7:0]                rdata_q;

  logic [NUM_REQ-1:0][7:0]   addr_arr;
  logic [NUM_REQ-1:0][7:0]   wdata_arr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_arr[gi]  = req_addr[8*gi +: 8];
      assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end
  endgenerate

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + IW1'(k);
      if (cand >= IW1'(NUM_REQ)) cand = cand - IW1'(NUM_REQ);
      if (!pick_found && req_valid[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  // A read may complete on the same cycle its data arrives.
  logic read_ready;
  assign read_ready = have_data | codec_data_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      ptr            <= '0;
      idx            <= '0;
      is_wr          <= 1'b0;
      cnt            <= '0;
      have_data      <= 1'b0;
      rdata_q        <= '0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      codec_rd_en    <= 1'b0;
      codec_wr_en    <= 1'b0;
      codec_reg_addr <= '0;
      codec_data_in  <= '0;
    end else begin
      // pulse outputs default low
      req_ready   <= '0;
      rsp_valid   <= '0;
      codec_rd_en <= 1'b0;
      codec_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found && !codec_busy) begin
            idx            <= pick_idx;
            is_wr          <= req_wr[pick_idx];
            codec_reg_addr <= addr_arr[pick_idx];
            codec_data_in  <= wdata_arr[pick_idx];
            // registered so they appear during the ISSUE cycle
            req_ready      <= ONE << pick_idx;
            codec_wr_en    <= req_wr[pick_idx];
            codec_rd_en    <= !req_wr[pick_idx];
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ptr       <= (idx == IW'(NUM_REQ-1)) ? '0 : idx + 1'b1;
          cnt       <= '0;
          have_data <= 1'b0;
          state     <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (codec_busy) begin
            cnt   <= '0;
            state <= S_WAIT_DONE;
          end else if (cnt == START_LIM) begin
            rsp_valid <= ONE << idx;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (codec_data_valid) begin
            rdata_q   <= codec_data_out;
            have_data <= 1'b1;
          end
          if (!codec_busy && (is_wr || read_ready)) begin
            rsp_valid <= ONE << idx;
            rsp_err   <= 1'b0;
            rsp_rdata <= is_wr ? 8'h00 :
                         (codec_data_valid ? codec_data_out : rdata_q);
            state     <= S_RESP;
          end else if (cnt == DONE_LIM) begin
            rsp_valid <= ONE << idx;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          rsp_rdata      <= '0;
          rsp_err        <= 1'b0;
          codec_reg_addr <= '0;
          codec_data_in  <= '0;
          have_data      <= 1'b0;
          cnt            <= '0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_reg_arbiter.sv
// tb_codec_reg_arbiter
//   Directed bench for codec_reg_arbiter. A timestamp-based transaction model
//   predicts every output on every cycle; directed steps add literal checks.
module tb_codec_reg_arbiter;
  localparam int NR  = 2;
  localparam int STO = 8;
  localparam int DTO = 40;

  logic            clk;
  logic            reset_n;
  logic [NR-1:0]   req_valid, req_wr;
  logic [8*NR-1:0] req_addr, req_wdata;
  logic [NR-1:0]   req_ready, rsp_valid;
  logic [7:0]      rsp_rdata;
  logic            rsp_err;
  logic            codec_rd_en, codec_wr_en;
  logic [7:0]      codec_reg_addr, codec_data_in;
  logic            codec_busy;
  logic [7:0]      codec_data_out;
  logic            codec_data_valid;

  codec_reg_arbiter #(.NUM_REQ(NR), .START_TO(STO), .DONE_TO(DTO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en),
    .codec_reg_addr(codec_reg_addr), .codec_data_in(codec_data_in),
    .codec_busy(codec_busy), .codec_data_out(codec_data_out),
    .codec_data_valid(codec_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model (timestamps, not states) -------------
  int            cyc = 0;
  bit            act = 0;
  int            t_iss, t_rise, t_resp = -1;
  int            m_idx, m_ptr = 0;
  bit            m_wr, m_got, m_err;
  logic [7:0]    m_addr, m_din, m_data;

  always @(negedge clk) begin : model
    logic [30:0]   got_v, exp_v;
    logic [NR-1:0] e_rdy, e_rsp;
    logic [7:0]    e_rdata, e_addr, e_din;
    logic          e_err, e_wr, e_rd;
    int            sel;
    if (!reset_n) begin
      act = 0; m_ptr = 0; t_resp = -1;
    end
    e_rdy = '0; e_rsp = '0; e_rdata = '0; e_err = 0; e_wr = 0; e_rd = 0;
    e_addr = act ? m_addr : 8'h00;
    e_din  = act ? m_din  : 8'h00;
    if (act && cyc == t_iss) begin
      e_rdy = NR'(1) << m_idx;
      e_wr  = m_wr;
      e_rd  = !m_wr;
    end
    if (act && cyc == t_resp) begin
      e_rsp   = NR'(1) << m_idx;
      e_err   = m_err;
      e_rdata = (!m_err && !m_wr) ? m_data : 8'h00;
    end
    got_v = {req_ready, rsp_valid, rsp_rdata, rsp_err, codec_rd_en, codec_wr_en,
             codec_reg_addr, codec_data_in};
    exp_v = {e_rdy, e_rsp, e_rdata, e_err, e_rd, e_wr, e_addr, e_din};
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_cycle%0d: got %h expected %h", cyc, got_v, exp_v);
    end
    // advance model with this cycle's inputs
    if (reset_n) begin
      if (act) begin
        if (cyc == t_resp) act = 0;
        else if (t_resp < 0 && cyc > t_iss) begin
          if (t_rise < 0) begin
            if (codec_busy) t_rise = cyc;
            else if (cyc - t_iss - 1 == STO) begin t_resp = cyc + 1; m_err = 1; end
          end else begin
            if (codec_data_valid) begin m_got = 1; m_data = codec_data_out; end
            if (!codec_busy && (m_wr || m_got)) t_resp = cyc + 1;
            else if (cyc - t_rise - 1 == DTO) begin t_resp = cyc + 1; m_err = 1; end
          end
        end
      end else if (!codec_busy && req_valid != '0) begin
        sel = -1;
        for (int k = 0; k < NR; k++)
          if (sel < 0 && req_valid[(m_ptr + k) % NR]) sel = (m_ptr + k) % NR;
        act = 1; t_iss = cyc + 1; t_rise = -1; t_resp = -1;
        m_got = 0; m_err = 0; m_data = 8'h00;
        m_idx = sel; m_wr = req_wr[sel];
        m_addr = req_addr[8*sel +: 8]; m_din = req_wdata[8*sel +: 8];
        m_ptr = (sel + 1) % NR;
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  logic [NR-1:0] l_rdy, l_rsp;
  logic [7:0]    l_rdata, l_addr, l_din;
  logic          l_err, l_wr_en, l_rd_en;

  // Capture the outputs of the current cycle, move to the next, then let any
  // requester that was accepted drop its valid.
  task automatic tick();
    @(negedge clk);
    l_rdy = req_ready; l_rsp = rsp_valid; l_rdata = rsp_rdata; l_err = rsp_err;
    l_wr_en = codec_wr_en; l_rd_en = codec_rd_en; l_addr = codec_reg_addr; l_din = codec_data_in;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (l_rdy[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
    req_wr[i] = wr; req_addr[8*i +: 8] = a; req_wdata[8*i +: 8] = d; req_valid[i] = 1'b1;
  endtask

  task automatic bound_fail(input string nm);
    n_tests++; n_fail++;
    $display("FAIL %s: event not seen within cycle bound", nm);
  endtask

  task automatic wait_rdy(input string nm, input int maxc, output int k);
    k = 0;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      if (l_rdy != '0) begin k = c; return; end
    end
    bound_fail(nm);
  endtask

  task automatic wait_rsp(input string nm, input int maxc, output int k);
    k = 0;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      if (l_rsp != '0) begin k = c; return; end
    end
    bound_fail(nm);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [NR-1:0] g;
    reset_n = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    codec_busy = 1'b0; codec_data_out = 8'h00; codec_data_valid = 1'b0;
    repeat (3) tick();
    chk("reset_ready", l_rdy, 0);
    chk("reset_rsp", l_rsp, 0);
    chk("reset_addr_data", {l_addr, l_din, l_rdata}, 0);
    chk("reset_strobes", {l_wr_en, l_rd_en, l_err}, 0);
    reset_n = 1'b1;
    tick();

    // 1: req0 write 0x04/0x5A
    set_req(0, 1'b1, 8'h04, 8'h5A);
    tick();
    chk("t1_no_early_ready", l_rdy, 0);
    tick();
    chk("t1_ready0", l_rdy, 2'b01);
    chk("t1_strobes", {l_wr_en, l_rd_en}, 2'b10);
    chk("t1_addr_data", {l_addr, l_din}, 16'h045A);
    tick();
    chk("t1_wr_one_cycle", l_wr_en, 0);
    codec_busy = 1'b1;
    repeat (5) tick();
    chk("t1_addr_held", {l_addr, l_din}, 16'h045A);
    codec_busy = 1'b0;
    wait_rsp("t1_rsp_wait", 10, k);
    chk("t1_rsp_latency", k, 2);
    chk("t1_rsp", {l_rsp, l_err}, 3'b010);

    // 2: req1 read 0x0A, data 0xC3 mid-busy
    set_req(1, 1'b0, 8'h0A, 8'h00);
    tick(); tick();
    chk("t2_ready1", l_rdy, 2'b10);
    chk("t2_strobes", {l_wr_en, l_rd_en, l_addr}, {2'b01, 8'h0A});
    codec_busy = 1'b1;
    tick(); tick();
    codec_data_valid = 1'b1; codec_data_out = 8'hC3;
    tick();
    codec_data_valid = 1'b0; codec_data_out = 8'h00;
    tick();
    codec_busy = 1'b0;
    wait_rsp("t2_rsp_wait", 10, k);
    chk("t2_rsp_latency", k, 2);
    chk("t2_rsp", {l_rsp, l_rdata, l_err}, {2'b10, 8'hC3, 1'b0});

    // 3: both requesters contend, four back-to-back grants
    set_req(0, 1'b1, 8'h20, 8'hA0);
    set_req(1, 1'b1, 8'h21, 8'hA1);
    for (int it = 0; it < 4; it++) begin
      wait_rdy("t3_rdy_wait", 10, k);
      g = l_rdy;
      chk($sformatf("t3_grant%0d", it), g, (it % 2 == 0) ? 2'b01 : 2'b10);
      if (it < 2) begin
        if (g[0]) set_req(0, 1'b1, 8'h20, 8'hA0);
        else      set_req(1, 1'b1, 8'h21, 8'hA1);
      end
      tick();
      codec_busy = 1'b1;
      tick(); tick();
      codec_busy = 1'b0;
      wait_rsp("t3_rsp_wait", 10, k);
      chk($sformatf("t3_rsp%0d", it), l_rsp, g);
    end

    // 4: busy never rises -> start timeout
    set_req(0, 1'b0, 8'h33, 8'h00);
    wait_rdy("t4_rdy_wait", 10, k);
    chk("t4_ready0", l_rdy, 2'b01);
    wait_rsp("t4_rsp_wait", STO + 10, k);
    chk("t4_timeout_latency", k, STO + 2);
    chk("t4_rsp_err", {l_rsp, l_rdata, l_err}, {2'b01, 8'h00, 1'b1});

    // 5: read data arrives 5 cycles after busy falls
    set_req(1, 1'b0, 8'h11, 8'h00);
    wait_rdy("t5_rdy_wait", 10, k);
    chk("t5_ready1", l_rdy, 2'b10);
    tick();
    codec_busy = 1'b1;
    repeat (3) tick();
    codec_busy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t5_hold%0d", c), l_rsp, 0);
    end
    codec_data_valid = 1'b1; codec_data_out = 8'h96;
    tick();
    chk("t5_no_rsp_on_valid", l_rsp, 0);
    codec_data_valid = 1'b0; codec_data_out = 8'h00;
    wait_rsp("t5_rsp_wait", 5, k);
    chk("t5_rsp_latency", k, 1);
    chk("t5_rsp", {l_rsp, l_rdata, l_err}, {2'b10, 8'h96, 1'b0});

    // 6: reset in WAIT_DONE, then normal grant with pointer back at 0
    set_req(0, 1'b1, 8'h77, 8'h12);
    wait_rdy("t6_rdy_wait", 10, k);
    tick();
    codec_busy = 1'b1;
    tick(); tick();
    chk("t6_addr_before_reset", {codec_reg_addr, codec_data_in}, 16'h7712);
    reset_n = 1'b0; codec_busy = 1'b0;
    #1;
    chk("t6_async_clear", {req_ready, rsp_valid, rsp_rdata, rsp_err, codec_rd_en,
                           codec_wr_en, codec_reg_addr, codec_data_in}, 0);
    tick(); tick();
    chk("t6_no_rsp_in_reset", l_rsp, 0);
    reset_n = 1'b1;
    tick();
    set_req(0, 1'b1, 8'h5C, 8'hE7);
    set_req(1, 1'b1, 8'h5D, 8'hE8);
    wait_rdy("t6_rdy_wait2", 10, k);
    chk("t6_grant_after_reset", l_rdy, 2'b01);
    tick();
    codec_busy = 1'b1;
    tick();
    codec_busy = 1'b0;
    wait_rsp("t6_rsp_wait", 10, k);
    chk("t6_rsp0", {l_rsp, l_err}, 3'b010);
    wait_rdy("t6_rdy_wait3", 10, k);
    chk("t6_grant1", l_rdy, 2'b10);
    tick();
    codec_busy = 1'b1;
    tick();
    codec_busy = 1'b0;
    wait_rsp("t6_rsp_wait2", 10, k);
    chk("t6_rsp1", {l_rsp, l_err}, 3'b100);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
